fmap_drain: RTL and testbench

FMAP_DRAIN -- requirements
Module: fmap_drain

---
 rtl/fmap_drain.sv | 139 +++++++++++++
 tb/tb_fmap_drain.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmap_drain.sv
// rtl/fmap_drain.sv - drains a feature map of channel vectors into a raster-ordered word stream
// Two-entry vector FIFO feeding a per-channel serializer that tracks row/col/channel position.
module fmap_drain #(
   parameter int DATA_W = 16,
   parameter int CH     = 64,
   parameter int MAP_W  = 111,
   parameter int MAP_H  = 111,
   localparam int CH_W  = (CH    > 1) ? $clog2(CH)    : 1,
   localparam int COL_W = (MAP_W > 1) ? $clog2(MAP_W) : 1,
   localparam int ROW_W = (MAP_H > 1) ? $clog2(MAP_H) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_data_valid,
   input  logic [CH*DATA_W-1:0] i_data,
   output logic                 i_ready,
   output logic                 o_valid,
   input  logic                 o_ready,
   output logic [DATA_W-1:0]    o_data,
   output logic [CH_W-1:0]      o_ch,
   output logic [COL_W-1:0]     o_col,
   output logic [ROW_W-1:0]     o_row,
   output logic                 o_last,
   output logic                 o_done,
   output logic                 o_overflow
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DRAIN = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [CH_W-1:0]  CH_MAX  = CH_W'(CH - 1);
   localparam logic [COL_W-1:0] COL_MAX = COL_W'(MAP_W - 1);
   localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(MAP_H - 1);

   logic [1:0]           state;
   logic [CH*DATA_W-1:0] mem [2];
   logic                 wr_ptr;
   logic                 rd_ptr;
   logic [1:0]           count;
   logic                 run;
   logic [CH_W-1:0]      ch;
   logic [COL_W-1:0]     col;
   logic [ROW_W-1:0]     row;

   logic full, empty, ch_end, col_end, row_end, last_word;
   logic word_hs, pop, push;

   assign empty     = (count == 2'd0);
   assign full      = (count == 2'd2);
   assign ch_end    = (ch  == CH_MAX);
   assign col_end   = (col == COL_MAX);
   assign row_end   = (row == ROW_MAX);
   assign last_word = ch_end & col_end & row_end;

   assign o_valid = (state == S_DRAIN);
   assign word_hs = o_valid & o_ready;
   assign pop     = word_hs & ch_end;

   // A full FIFO still accepts when the head is being popped this cycle, unless that pop ends the map.
   assign i_ready = run & (state != S_DONE) & (~full | (pop & ~last_word));
   assign push    = i_data_valid & i_ready;

   assign o_data = o_valid ? mem[rd_ptr][ch*DATA_W +: DATA_W] : '0;
   assign o_last = o_valid & last_word;
   assign o_ch   = ch;
   assign o_col  = col;
   assign o_row  = row;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         count      <= 2'd0;
         run        <= 1'b0;
         ch         <= '0;
         col        <= '0;
         row        <= '0;
         o_done     <= 1'b0;
         o_overflow <= 1'b0;
      end else begin
         run <= 1'b1;
         if (push) begin
            wr_ptr <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
         if (i_data_valid && !i_ready && state != S_DONE) begin
            o_overflow <= 1'b1;
         end
         if (word_hs) begin
            if (ch_end) begin
               ch <= '0;
               if (col_end) begin
                  col <= '0;
                  row <= row_end ? '0 : row + 1'b1;
               end else begin
                  col <= col + 1'b1;
               end
            end else begin
               ch <= ch + 1'b1;
            end
         end
         case (state)
            S_IDLE: begin
               if (!empty) begin
                  state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (pop) begin
                  if (last_word) begin
                     state  <= S_DONE;
                     o_done <= 1'b1;
                  end else if (count == 2'd1 && !push) begin
                     state <= S_IDLE;
                  end
               end
            end
            S_DONE:  state <= S_DONE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fmap_drain.sv
// tb/tb_fmap_drain.sv - randomized scoreboard bench for fmap_drain
// Expected words come from a raster-order model indexed by accepted-vector count.
module tb_fmap_drain;

   localparam int DW = 16;
   localparam int NCH = 4;
   localparam int MW = 3;
   localparam int MH = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              i_data_valid = 1'b0;
   logic [NCH*DW-1:0] i_data = '0;
   logic              i_ready;
   logic              o_valid;
   logic              o_ready = 1'b0;
   logic [DW-1:0]     o_data;
   logic [1:0]        o_ch;
   logic [1:0]        o_col;
   logic [1:0]        o_row;
   logic              o_last;
   logic              o_done;
   logic              o_overflow;

   fmap_drain #(.DATA_W(DW), .CH(NCH), .MAP_W(MW), .MAP_H(MH)) dut (
      .clk(clk), .rst(rst), .i_data_valid(i_data_valid), .i_data(i_data),
      .i_ready(i_ready), .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
      .o_ch(o_ch), .o_col(o_col), .o_row(o_row), .o_last(o_last),
      .o_done(o_done), .o_overflow(o_overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] data;
      int            ch;
      int            col;
      int            row;
      bit            last;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   vec_n = 0;
   int   words_popped = 0;
   int   ready_mode = 0;
   bit   ready_val = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Model: vector k lands at row k/MW, col k%MW; its channels come out in order.
   task automatic expect_vec(input logic [NCH*DW-1:0] v);
      exp_t e;
      for (int c = 0; c < NCH; c++) begin
         e.data = v[c*DW +: DW];
         e.ch   = c;
         e.col  = vec_n % MW;
         e.row  = vec_n / MW;
         e.last = (vec_n == MW*MH-1) && (c == NCH-1);
         exp_q.push_back(e);
      end
      vec_n++;
   endtask

   task automatic offer(input logic [NCH*DW-1:0] v, output bit acc);
      i_data = v;
      i_data_valid = 1'b1;
      @(negedge clk);
      acc = i_ready;
      if (acc) expect_vec(v);
      tick();
      i_data_valid = 1'b0;
   endtask

   task automatic send_vec(input logic [NCH*DW-1:0] v);
      bit acc = 1'b0;
      for (int t = 0; t < 500 && !acc; t++) offer(v, acc);
      chk("send_accept_timeout", acc, 1);
   endtask

   task automatic wait_empty();
      bit ok = 1'b0;
      for (int t = 0; t < 3000; t++) begin
         if (exp_q.size() == 0 && !o_valid) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      chk("drain_timeout", ok, 1);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      i_data_valid = 1'b0;
      exp_q.delete();
      vec_n = 0;
      #1;
      chk("rst_o_valid", o_valid, 0);
      chk("rst_i_ready", i_ready, 0);
      chk("rst_flags", {o_done, o_overflow, o_last}, 0);
      chk("rst_pos", {o_row, o_col, o_ch}, 0);
      chk("rst_o_data", o_data, 0);
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("release_i_ready_low", i_ready, 0);
      tick();
      chk("release_i_ready_high", i_ready, 1);
   endtask

   function automatic logic [NCH*DW-1:0] rand_vec();
      logic [NCH*DW-1:0] v;
      for (int c = 0; c < NCH; c++) v[c*DW +: DW] = DW'($urandom);
      return v;
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       o_ready = ready_val;
            1:       o_ready = ~o_ready;
            default: o_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: pops the scoreboard on each word handshake and checks hold-under-backpressure.
   initial begin
      bit            hold_prev = 1'b0;
      logic [DW-1:0] prev_data;
      logic [1:0]    prev_ch;
      exp_t          e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            hold_prev = 1'b0;
         end else begin
            if (hold_prev) begin
               chk("hold_stable", {o_valid, o_data, o_ch}, {1'b1, prev_data, prev_ch});
            end
            if (o_valid && o_ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_word", o_data, 'hffff_ffff);
               end else begin
                  e = exp_q.pop_front();
                  chk("word_data", o_data, e.data);
                  chk("word_pos", {int'(o_row), int'(o_col), int'(o_ch)}, {e.row, e.col, e.ch});
                  chk("word_last", o_last, e.last);
               end
               words_popped++;
            end
            hold_prev = o_valid && !o_ready;
            prev_data = o_data;
            prev_ch   = o_ch;
         end
      end
   end

   initial begin
      bit                acc;
      logic [NCH*DW-1:0] v;
      int                base;
      bit                found;

      do_reset();

      // single vector, always ready
      ready_mode = 0;
      ready_val = 1'b1;
      tick();
      for (int c = 0; c < NCH; c++) v[c*DW +: DW] = 16'h0100 + 16'(c);
      offer(v, acc);
      chk("single_accept", acc, 1);
      chk("latency_before", o_valid, 0);
      tick();
      chk("latency_after", o_valid, 1);
      chk("first_word", o_data, 16'h0100);
      wait_empty();
      chk("single_end_pos", {o_row, o_col, o_ch}, {2'd0, 2'd1, 2'd0});

      // toggling backpressure
      ready_mode = 1;
      send_vec(rand_vec());
      send_vec(rand_vec());
      wait_empty();

      // push/pop at count=2 on the final channel handshake
      ready_mode = 0;
      ready_val = 1'b0;
      tick();
      send_vec(rand_vec());
      send_vec(rand_vec());
      chk("full_i_ready", i_ready, 0);
      ready_val = 1'b1;
      found = 1'b0;
      for (int t = 0; t < 100; t++) begin
         tick();
         if (o_valid && o_ready && o_ch == 2'(NCH-1)) begin
            found = 1'b1;
            break;
         end
      end
      chk("pushpop_reach", found, 1);
      chk("pushpop_i_ready", i_ready, 1);
      offer(rand_vec(), acc);
      chk("pushpop_accept", acc, 1);
      chk("pushpop_still_full", i_ready, 0);
      chk("pushpop_no_ovf", o_overflow, 0);
      wait_empty();

      // overflow with stalled output
      do_reset();
      ready_val = 1'b0;
      offer(rand_vec(), acc);
      chk("ovf_acc0", acc, 1);
      offer(rand_vec(), acc);
      chk("ovf_acc1", acc, 1);
      chk("ovf_i_ready", i_ready, 0);
      offer(rand_vec(), acc);
      chk("ovf_acc2", acc, 0);
      chk("ovf_flag", o_overflow, 1);
      ready_val = 1'b1;
      wait_empty();
      repeat (5) tick();
      chk("ovf_sticky", o_overflow, 1);

      // reset in the middle of the second vector
      do_reset();
      base = words_popped;
      send_vec(rand_vec());
      send_vec(rand_vec());
      found = 1'b0;
      for (int t = 0; t < 200; t++) begin
         if (words_popped >= base + NCH + 2) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      chk("midrst_reach", found, 1);
      #1;
      rst = 1'b0;
      #1;
      chk("midrst_valid", o_valid, 0);
      chk("midrst_data", o_data, 0);
      chk("midrst_pos", {o_row, o_col, o_ch}, 0);
      chk("midrst_i_ready", i_ready, 0);
      do_reset();
      send_vec(rand_vec());
      wait_empty();
      chk("midrst_end_pos", {o_row, o_col}, {2'd0, 2'd1});

      // full map with random backpressure and gaps
      do_reset();
      ready_mode = 2;
      base = words_popped;
      for (int k = 0; k < MW*MH; k++) begin
         repeat ($urandom_range(0, 2)) tick();
         send_vec(rand_vec());
      end
      wait_empty();
      chk("map_words", words_popped - base, MW*MH*NCH);
      chk("map_done", o_done, 1);
      chk("map_i_ready", i_ready, 0);
      offer(rand_vec(), acc);
      chk("done_ignores", acc, 0);
      found = 1'b0;
      for (int t = 0; t < 10; t++) begin
         tick();
         if (o_valid) found = 1'b1;
      end
      chk("done_quiet", found, 0);
      chk("done_sticky", o_done, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
